// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, late results queue in a small FIFO.
// Define WBARB_STARVE_EN to enable the starvation counter and the one-cycle forced-drain stall.
module wb_port_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_dest,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // state | meaning
    // IDLE  | FIFO empty
    // PEND  | late results waiting for an idle WB slot
    // FORCE | pipeline stalled one cycle while the FIFO head drains
`ifdef WBARB_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;
`else
    typedef enum logic [1:0] {IDLE, PEND} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            live_q [DEPTH];
    logic            live_d [DEPTH];
    logic [4:0]      dest_q [DEPTH];
    logic [4:0]      dest_d [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     data_d [DEPTH];
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [31:0]     rf_wdata_q, rf_wdata_d;

    logic full, empty, commit, push, pop;

    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign lu_ready = !full;

`ifdef WBARB_STARVE_EN
    logic [SW-1:0] starve_q, starve_d;
    assign pipe_stall = (state_q == FORCE);
`else
    assign pipe_stall = 1'b0;
`endif

    assign commit = wb_regwrite && !pipe_stall && (wb_dest != 5'd0);
    // Writes to x0 are accepted from the late unit but never stored.
    assign push   = lu_valid && lu_ready && (lu_dest != 5'd0);
    assign pop    = !empty && !commit;

    always_comb begin
        live_d     = live_q;
        dest_d     = dest_q;
        data_d     = data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (commit) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dest_q[i] == wb_dest) live_d[i] = 1'b0;
            end
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_dest;
            rf_wdata_d = wb_data;
        end else if (pop && live_q[rd_ptr_q]) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = dest_q[rd_ptr_q];
            rf_wdata_d = data_q[rd_ptr_q];
        end

        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

        // An entry pushed alongside a commit to the same register is already stale.
        if (push) begin
            live_d[wr_ptr_q] = !(commit && (lu_dest == wb_dest));
            dest_d[wr_ptr_q] = lu_dest;
            data_d[wr_ptr_q] = lu_data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

`ifdef WBARB_STARVE_EN
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (push) state_d = PEND;
            end
            PEND: begin
                if (pop) begin
                    starve_d = '0;
                    if ((cnt_q == CW'(1)) && !push) state_d = IDLE;
                end else if (commit) begin
                    if (starve_q == SW'(STARVE_MAX - 1)) begin
                        state_d  = FORCE;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            FORCE: begin
                starve_d = '0;
                state_d  = ((cnt_q > CW'(1)) || push) ? PEND : IDLE;
            end
            default: begin
                state_d  = IDLE;
                starve_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`else
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (push) state_d = PEND;
            PEND:    if (pop && (cnt_q == CW'(1)) && !push) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            live_q     <= '{default: 1'b0};
            dest_q     <= '{default: 5'd0};
            data_q     <= '{default: 32'd0};
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            live_q     <= live_d;
            dest_q     <= dest_d;
            data_q     <= data_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed table, corner sequences, randomized run vs. queue model.
module tb_wb_port_arbiter;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_regwrite;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_dest;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .wb_regwrite(wb_regwrite), .wb_dest(wb_dest), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_dest(lu_dest), .lu_data(lu_data),
        .lu_ready(lu_ready), .pipe_stall(pipe_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: an ordered list of pending results plus a starvation tally.
    typedef struct {
        logic        live;
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;
    ent_t        mq[$];
    int          m_starve = 0;
    bit          m_force  = 0;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    logic        s_stall, s_ready, s_we;
    logic [4:0]  s_waddr;
    logic [31:0] s_wdata;

    task automatic do_reset();
        rst = 1'b1;
        wb_regwrite = 1'b0; wb_dest = '0; wb_data = '0;
        lu_valid = 1'b0; lu_dest = '0; lu_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_starve = 0;
        m_force  = 0;
    endtask

    // One clock: drive at negedge, check combinational outputs, step model, check registered outputs.
    task automatic cycle(input logic wr, input logic [4:0] wd, input logic [31:0] wdat,
                         input logic lv, input logic [4:0] ld, input logic [31:0] ldat);
        bit stall, ready, cmt, nonempty, popped;
        wb_regwrite = wr; wb_dest = wd; wb_data = wdat;
        lu_valid = lv; lu_dest = ld; lu_data = ldat;
        #1;
        s_stall = pipe_stall;
        s_ready = lu_ready;
`ifdef WBARB_STARVE_EN
        stall = m_force;
`else
        stall = 0;
`endif
        ready = (mq.size() < DEPTH);
        chk("pipe_stall", {31'd0, s_stall}, {31'd0, stall});
        chk("lu_ready", {31'd0, s_ready}, {31'd0, ready});

        cmt = wr && !stall && (wd != 5'd0);
        nonempty = (mq.size() > 0);
        if (cmt) foreach (mq[i]) if (mq[i].dest == wd) mq[i].live = 1'b0;
        popped = nonempty && !cmt;
        m_we = 1'b0;
        if (cmt) begin
            m_we = 1'b1; m_waddr = wd; m_wdata = wdat;
        end else if (popped) begin
            if (mq[0].live) begin
                m_we = 1'b1; m_waddr = mq[0].dest; m_wdata = mq[0].data;
            end
            mq.delete(0);
        end
        if (lv && ready && (ld != 5'd0))
            mq.push_back('{live: !(cmt && (ld == wd)), dest: ld, data: ldat});
        if (stall) begin
            m_force = 0; m_starve = 0;
        end else if (popped) begin
            m_starve = 0;
        end else if (cmt && nonempty) begin
            if (m_starve == STARVE_MAX - 1) begin
                m_force = 1; m_starve = 0;
            end else begin
                m_starve++;
            end
        end

        @(posedge clk);
        #1;
        s_we = rf_we; s_waddr = rf_waddr; s_wdata = rf_wdata;
        chk("rf_we", {31'd0, s_we}, {31'd0, m_we});
        if (m_we) begin
            chk("rf_waddr", {27'd0, s_waddr}, {27'd0, m_waddr});
            chk("rf_wdata", s_wdata, m_wdata);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  wd;
        logic [31:0] wdat;
        logic        lv;
        logic [4:0]  ld;
        logic [31:0] ldat;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;
    vec_t tbl[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b1, 5'd5,  32'hDEADBEEF};
        tbl[3]  = '{1'b1, 5'd3,  32'h11,   1'b1, 5'd7, 32'h22,       1'b1, 5'd3,  32'h11};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  32'h22};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd9, 32'hAAAA,     1'b0, 5'd0,  32'h0};
        tbl[6]  = '{1'b1, 5'd9,  32'hBBBB, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9,  32'hBBBB};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0, 32'h1234,     1'b0, 5'd0,  32'h0};
        tbl[10] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0};
        tbl[11] = '{1'b1, 5'd0,  32'h5555, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0};
        tbl[12] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0};
        tbl[13] = '{1'b1, 5'd12, 32'hCAFE, 1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 32'hCAFE};
        tbl[14] = '{1'b1, 5'd4,  32'h44,   1'b1, 5'd4, 32'h40,       1'b1, 5'd4,  32'h44};
        tbl[15] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0};
        tbl[16] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0};

        @(negedge clk);
        do_reset();
        chk("reset rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("reset rf_wdata", rf_wdata, 32'd0);
        chk("reset pipe_stall", {31'd0, pipe_stall}, 32'd0);
        chk("reset lu_ready", {31'd0, lu_ready}, 32'd1);

        foreach (tbl[i]) begin
            cycle(tbl[i].wr, tbl[i].wd, tbl[i].wdat, tbl[i].lv, tbl[i].ld, tbl[i].ldat);
            chk($sformatf("tbl[%0d] we", i), {31'd0, s_we}, {31'd0, tbl[i].e_we});
            if (tbl[i].e_we) begin
                chk($sformatf("tbl[%0d] waddr", i), {27'd0, s_waddr}, {27'd0, tbl[i].e_waddr});
                chk($sformatf("tbl[%0d] wdata", i), s_wdata, tbl[i].e_wdata);
            end
        end

        // Starvation: one queued entry while WB writes r1 every cycle.
        do_reset();
`ifdef WBARB_STARVE_EN
        for (int k = 0; k <= 10; k++) begin
            cycle(1'b1, 5'd1, 32'h100, (k == 0), 5'd6, 32'h66);
            chk($sformatf("starve stall k=%0d", k), {31'd0, s_stall}, {31'd0, (k == 9)});
            chk($sformatf("starve waddr k=%0d", k), {27'd0, s_waddr}, (k == 9) ? 32'd6 : 32'd1);
            chk($sformatf("starve wdata k=%0d", k), s_wdata, (k == 9) ? 32'h66 : 32'h100);
        end
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("starve drained", {31'd0, s_we}, 32'd0);
`else
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 5'd1, 32'h100, (k == 0), 5'd6, 32'h66);
            chk($sformatf("nostarve stall k=%0d", k), {31'd0, s_stall}, 32'd0);
            chk($sformatf("nostarve waddr k=%0d", k), {27'd0, s_waddr}, 32'd1);
        end
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("nostarve drain we", {31'd0, s_we}, 32'd1);
        chk("nostarve drain waddr", {27'd0, s_waddr}, 32'd6);
        chk("nostarve drain wdata", s_wdata, 32'h66);
`endif

        // Full: four pushes under continuous WB writes, then backpressure and drain.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 5'd1, 32'(k), 1'b1, 5'(20 + k), 32'hA0 + 32'(k));
            chk($sformatf("full ready k=%0d", k), {31'd0, s_ready}, 32'd1);
        end
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd24, 32'hA4);
        chk("full ready low", {31'd0, s_ready}, 32'd0);
        chk("full first pop", {27'd0, s_waddr}, 32'd20);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("full ready back", {31'd0, s_ready}, 32'd1);
        chk("full pop r21", {27'd0, s_waddr}, 32'd21);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("full pop r22", {27'd0, s_waddr}, 32'd22);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("full pop r23", s_wdata, 32'hA3);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("full refused push", {31'd0, s_we}, 32'd0);

        // Reset with two entries pending drops them.
        cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hB0);
        cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hB1);
        do_reset();
        chk("rst lu_ready", {31'd0, lu_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            chk($sformatf("rst no stale k=%0d", k), {31'd0, s_we}, 32'd0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int pct;
            if (n == 1500) do_reset();
            pct = (n < 1000) ? 50 : (n < 2000) ? 85 : 20;
            cycle(($urandom_range(0, 99) < pct), 5'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
